hdmi_packet_scheduler: RTL

HDMI_PACKET_SCHEDULER -- requirements
Module: hdmi_packet_scheduler

---
 rtl/hdmi_pkg.sv | 13 +
 rtl/hdmi_rr_arbiter.sv | 25 ++
 rtl/hdmi_packet_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared source indices and scheduler FSM states for the HDMI packet scheduler
package hdmi_pkg;

    localparam int SRC_AUDIO   = 0;
    localparam int SRC_ACR     = 1;
    localparam int SRC_IF_BASE = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_DECIDE = 1'b1
    } sched_state_t;

endpackage

// File: rtl/hdmi_rr_arbiter.sv
// rtl/hdmi_rr_arbiter.sv - round-robin picker: first requester strictly after ptr, wrapping to index 0
module hdmi_rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] above;
    logic [N-1:0] hi;

    always_comb begin
        above = '0;
        for (int j = 0; j < N; j++) begin
            above[j] = (j > int'(ptr));
        end
    end

    // Lowest set bit of the upper window wins; otherwise wrap to the lowest requester overall.
    assign hi    = req & above;
    assign grant = (hi != '0) ? (hi & (~hi + N'(1))) : (req & (~req + N'(1)));

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// rtl/hdmi_packet_scheduler.sv - data island packet scheduler (audio > ACR > due InfoFrames round-robin); null stats under HDMI_PKT_STATS_EN
module hdmi_packet_scheduler
    import hdmi_pkg::*;
#(
    parameter int NUM_SRC       = 5,
    parameter int MAX_AUDIO_RUN = 3
) (
    input  logic                       clk_pixel,
    input  logic                       reset,
    input  logic                       packet_enable,
    input  logic                       video_field_end,
    input  logic [NUM_SRC-1:0]         req,
    output logic [NUM_SRC-1:0]         grant,
    output logic [$clog2(NUM_SRC)-1:0] sel,
    output logic                       null_packet,
    output logic [15:0]                null_count
);

    localparam int NUM_IF = NUM_SRC - SRC_IF_BASE;
    localparam int SW     = $clog2(NUM_SRC);
    localparam int PW     = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;
    localparam int RW     = $clog2(MAX_AUDIO_RUN + 1);

    sched_state_t      state, state_next;
    logic              pending, pending_next;
    logic              decide;
    logic [NUM_IF-1:0] due;
    logic [PW-1:0]     rr_ptr;
    logic [RW-1:0]     audio_run;

    logic [NUM_IF-1:0]  if_req, if_gnt;
    logic               if_any, starve, win_if;
    logic [NUM_SRC-1:0] win_grant;
    logic [SW-1:0]      win_sel;
    logic [PW-1:0]      if_idx;

    assign if_req = req[NUM_SRC-1:SRC_IF_BASE] & due;
    assign if_any = |if_req;
    // A full audio run yields the slot to a waiting InfoFrame, bypassing ACR as well.
    assign starve = if_any && (audio_run == RW'(MAX_AUDIO_RUN));

    hdmi_rr_arbiter #(.N(NUM_IF), .PW(PW)) u_rr (
        .req   (if_req),
        .ptr   (rr_ptr),
        .grant (if_gnt)
    );

    always_comb begin
        state_next   = state;
        pending_next = pending;
        decide       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (packet_enable || pending) begin
                    decide       = 1'b1;
                    state_next   = ST_DECIDE;
                    pending_next = pending && packet_enable;
                end
            end
            ST_DECIDE: begin
                state_next   = ST_IDLE;
                pending_next = pending || packet_enable;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        win_grant = '0;
        win_sel   = sel;
        win_if    = 1'b0;
        if_idx    = rr_ptr;
        if (req[SRC_AUDIO] && !starve) begin
            win_grant[SRC_AUDIO] = 1'b1;
            win_sel              = SW'(SRC_AUDIO);
        end else if (req[SRC_ACR] && !starve) begin
            win_grant[SRC_ACR] = 1'b1;
            win_sel            = SW'(SRC_ACR);
        end else if (if_any) begin
            win_if                               = 1'b1;
            win_grant[NUM_SRC-1:SRC_IF_BASE]     = if_gnt;
            for (int j = 0; j < NUM_IF; j++) begin
                if (if_gnt[j]) begin
                    if_idx  = PW'(j);
                    win_sel = SW'(j + SRC_IF_BASE);
                end
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            grant       <= '0;
            sel         <= '0;
            null_packet <= 1'b0;
            due         <= '0;
            rr_ptr      <= PW'(NUM_IF - 1);
            audio_run   <= '0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            grant       <= decide ? win_grant : '0;
            null_packet <= decide && (win_grant == '0);
            if (decide) begin
                sel <= win_sel;
                if (win_grant[SRC_AUDIO])
                    audio_run <= (audio_run == RW'(MAX_AUDIO_RUN)) ? audio_run : audio_run + 1'b1;
                else
                    audio_run <= '0;
                if (win_if)
                    rr_ptr <= if_idx;
            end
            // Field end re-arms every InfoFrame, overriding a clear from a same-cycle grant.
            if (video_field_end)
                due <= '1;
            else if (decide && win_if)
                due <= due & ~if_gnt;
        end
    end

`ifdef HDMI_PKT_STATS_EN
    logic [15:0] null_acc, null_acc_next;

    always_comb begin
        null_acc_next = null_acc;
        if (null_packet && (null_acc != 16'hFFFF))
            null_acc_next = null_acc + 16'd1;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            null_acc   <= '0;
            null_count <= '0;
        end else if (video_field_end) begin
            null_count <= null_acc_next;
            null_acc   <= '0;
        end else begin
            null_acc <= null_acc_next;
        end
    end
`else
    assign null_count = '0;
`endif

endmodule
